// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Serial bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input bit parity_en,
                                    input bit two_stop_bits);
    return 1 + data_bits + (parity_en ? 1 : 0) + (two_stop_bits ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty are distinguishable.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frame format is latched per frame at pop time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               baud_tick,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_BITS-1:0]               s_data,
  input  logic [1:0]                         parity_mode,
  input  logic                               two_stop,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               frame_done
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  tx_state_e             state, state_n;
  logic [TW-1:0]         tick_cnt, tick_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic                  stop_idx, stop_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic                  par_en, par_en_n;
  logic                  par_bit, par_bit_n;
  logic                  two_r, two_n;
  logic                  tx_n;
  logic                  done_n;
  logic                  start_frame;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;
  parity_e               pm;

  assign pm = parity_e'(parity_mode);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_ready = !fifo_full;
  assign busy    = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      two_r      <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_idx    <= bit_n;
      stop_idx   <= stop_n;
      shreg      <= shreg_n;
      par_en     <= par_en_n;
      par_bit    <= par_bit_n;
      two_r      <= two_n;
      tx         <= tx_n;
      frame_done <= done_n;
    end
  end

  // Every bit is held for OVERSAMPLE ticks; the data bit on tx is always shreg[0].
  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_idx;
    stop_n      = stop_idx;
    shreg_n     = shreg;
    par_en_n    = par_en;
    par_bit_n   = par_bit;
    two_n       = two_r;
    tx_n        = tx;
    done_n      = 1'b0;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;

    if (baud_tick) begin
      case (state)
        ST_IDLE: begin
          tx_n = 1'b1;
          if (!fifo_empty) start_frame = 1'b1;
        end
        ST_START: begin
          if (tick_cnt != '0) tick_n = tick_cnt - 1'b1;
          else begin
            tick_n  = TICK_RELOAD;
            state_n = ST_DATA;
            bit_n   = '0;
            tx_n    = shreg[0];
          end
        end
        ST_DATA: begin
          if (tick_cnt != '0) tick_n = tick_cnt - 1'b1;
          else begin
            tick_n = TICK_RELOAD;
            if (bit_idx == LAST_BIT) begin
              if (par_en) begin
                state_n = ST_PARITY;
                tx_n    = par_bit;
              end else begin
                state_n = ST_STOP;
                stop_n  = 1'b0;
                tx_n    = 1'b1;
              end
            end else begin
              bit_n   = bit_idx + 1'b1;
              shreg_n = shreg >> 1;
              tx_n    = shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick_cnt != '0) tick_n = tick_cnt - 1'b1;
          else begin
            tick_n  = TICK_RELOAD;
            state_n = ST_STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt != '0) tick_n = tick_cnt - 1'b1;
          else if (two_r && !stop_idx) begin
            tick_n = TICK_RELOAD;
            stop_n = 1'b1;
            tx_n   = 1'b1;
          end else begin
            done_n = 1'b1;
            if (!fifo_empty) start_frame = 1'b1;
            else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
        end
      endcase

      // Shared by IDLE and the end of STOP so queued frames go out with no gap.
      if (start_frame) begin
        fifo_pop = 1'b1;
        shreg_n  = fifo_rdata;
        two_n    = two_stop;
        par_en_n = (pm != PAR_NONE);
        case (pm)
          PAR_EVEN: par_bit_n = ^fifo_rdata;
          PAR_ODD:  par_bit_n = ~^fifo_rdata;
          default:  par_bit_n = 1'b1;
        endcase
        state_n = ST_START;
        tick_n  = TICK_RELOAD;
        tx_n    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: records tx after every baud_tick edge and checks frames by tick index.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       gen_tick;
  logic       man_tick;
  logic       tick_en;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       frame_done;

  int   total = 0;
  int   bad   = 0;
  logic trace[$];
  int   done_q[$];
  int   done_cnt = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        ts;
    int          len;
    logic [11:0] levels;
  } vec_t;

  vec_t vecs[7];

  assign baud_tick = gen_tick | man_tick;

  uart_tx_fifo #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    gen_tick = 1'b0;
    forever begin
      @(negedge clk);
      gen_tick = tick_en && !gen_tick;
    end
  end

  // trace[k] is the tx level just after the k-th baud_tick edge since the last clear.
  initial begin
    forever begin
      @(posedge clk);
      if (baud_tick) begin
        #1;
        trace.push_back(tx);
        if (frame_done) begin
          done_cnt++;
          done_q.push_back(trace.size() - 1);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic trace_at(input int idx);
    if (idx < 0 || idx >= trace.size()) return 1'bx;
    return trace[idx];
  endfunction

  function automatic int find_start(input int from);
    for (int k = from; k < trace.size(); k++)
      if (trace[k] === 1'b0) return k;
    return -1;
  endfunction

  task automatic clear_trace();
    trace.delete();
    done_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_trace(input int n, input int limit, input string name);
    int c = 0;
    while (trace.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    check_output({name, " reached"}, 32'(trace.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int limit, input string name);
    int c = 0;
    while (done_cnt < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    check_output({name, " frame_done reached"}, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  // 8N1 frame starting at tick index s: start low, data at bit centres, stop high.
  task automatic check_byte_frame(input int s, input logic [7:0] exp, input string name);
    logic [7:0] got;
    check_output({name, " start"}, 32'({trace_at(s), trace_at(s + 15)}), 32'd0);
    for (int i = 0; i < 8; i++) got[i] = trace_at(s + 16 * (i + 1) + 8);
    check_output({name, " data"}, 32'(got), 32'(exp));
    check_output({name, " stop"}, 32'({trace_at(s + 152), trace_at(s + 159)}), 32'd3);
  endtask

  // Push one byte, flip the frame config once the frame is underway, wait for it to finish.
  task automatic apply_stimulus(input int v);
    clear_trace();
    parity_mode = vecs[v].pm;
    two_stop    = vecs[v].ts;
    push_byte(vecs[v].data);
    wait_trace(40, 200, $sformatf("v%0d mid-frame", v));
    parity_mode = ~vecs[v].pm;
    two_stop    = ~vecs[v].ts;
    wait_done(1, 1000, $sformatf("v%0d", v));
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int s;
    int hits;
    logic [7:0] b4 [9];
    logic [7:0] b5 [4];

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; parity_mode = 2'b00;
    two_stop = 1'b0; tick_en = 1'b0; man_tick = 1'b0;

    // levels: tx per bit period in time order, read left to right; padded with 1s
    vecs[0] = '{data: 8'hA5, pm: 2'b00, ts: 1'b0, len: 10, levels: 12'b010100101111};
    vecs[1] = '{data: 8'h07, pm: 2'b01, ts: 1'b0, len: 11, levels: 12'b011100000111};
    vecs[2] = '{data: 8'h07, pm: 2'b10, ts: 1'b0, len: 11, levels: 12'b011100000011};
    vecs[3] = '{data: 8'h07, pm: 2'b11, ts: 1'b0, len: 11, levels: 12'b011100000111};
    vecs[4] = '{data: 8'h00, pm: 2'b00, ts: 1'b1, len: 11, levels: 12'b000000000111};
    vecs[5] = '{data: 8'h3C, pm: 2'b01, ts: 1'b1, len: 12, levels: 12'b000111100011};
    vecs[6] = '{data: 8'hFF, pm: 2'b10, ts: 1'b0, len: 11, levels: 12'b011111111111};

    repeat (3) @(negedge clk);
    check_output("reset tx", 32'(tx), 32'd1);
    check_output("reset s_ready", 32'(s_ready), 32'd1);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset fifo_count", 32'(fifo_count), 32'd0);
    check_output("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (10) @(negedge clk);
    check_output("idle tx", 32'(tx), 32'd1);
    check_output("idle busy", 32'(busy), 32'd0);

    $display("[TB] frame format vectors");
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(v);
      s = find_start(0);
      for (int i = 0; i < vecs[v].len; i++) begin
        hits = 0;
        for (int k = 0; k < 16; k++)
          if (trace_at(s + 16 * i + k) === vecs[v].levels[11 - i]) hits++;
        check_output($sformatf("v%0d bit%0d ticks at level", v, i), 32'(hits), 32'd16);
      end
      check_output($sformatf("v%0d frame_done count", v), 32'(done_cnt), 32'd1);
      check_output($sformatf("v%0d frame_done tick", v),
                   32'((done_q.size() > 0) ? done_q[0] : -1), 32'(s + 16 * vecs[v].len));
      check_output($sformatf("v%0d line idle after", v),
                   32'(trace_at(s + 16 * vecs[v].len)), 32'd1);
      check_output($sformatf("v%0d busy after", v), 32'(busy), 32'd0);
    end

    $display("[TB] fill fifo with ticks stopped, then back-to-back drain");
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tick_en     = 1'b0;
    repeat (4) @(negedge clk);
    b4 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h3C, 8'h99, 8'h66, 8'hEE};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s_data  = b4[i];
      s_valid = 1'b1;
    end
    @(negedge clk);
    check_output("t4 s_ready when full", 32'(s_ready), 32'd0);
    check_output("t4 fifo_count when full", 32'(fifo_count), 32'd8);
    s_valid = 1'b0;
    clear_trace();
    tick_en = 1'b1;
    wait_trace(1, 20, "t4 first tick");
    check_output("t4 fifo_count after first pop", 32'(fifo_count), 32'd7);
    check_output("t4 s_ready after first pop", 32'(s_ready), 32'd1);
    wait_done(8, 4000, "t4");
    s = find_start(0);
    check_output("t4 first start tick", 32'(s), 32'd0);
    for (int f = 0; f < 8; f++) begin
      check_byte_frame(s + 160 * f, b4[f], $sformatf("t4 frame%0d", f));
      check_output($sformatf("t4 frame%0d done tick", f),
                   32'((done_q.size() > f) ? done_q[f] : -1), 32'(s + 160 * (f + 1)));
    end
    repeat (60) @(negedge clk);
    check_output("t4 no extra frame", 32'(done_cnt), 32'd8);
    check_output("t4 busy after drain", 32'(busy), 32'd0);

    $display("[TB] push and pop on the same edge across pointer wrap");
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    b5 = '{8'h31, 8'h32, 8'h33, 8'h34};
    for (int i = 0; i < 3; i++) push_byte(b5[i]);
    check_output("t5 count before", 32'(fifo_count), 32'd3);
    clear_trace();
    @(negedge clk);
    s_data   = b5[3];
    s_valid  = 1'b1;
    man_tick = 1'b1;
    @(negedge clk);
    s_valid  = 1'b0;
    man_tick = 1'b0;
    s_data   = 8'hEE;
    check_output("t5 count after push+pop", 32'(fifo_count), 32'd3);
    check_output("t5 busy", 32'(busy), 32'd1);
    tick_en = 1'b1;
    wait_done(4, 2000, "t5");
    s = find_start(0);
    check_output("t5 first start tick", 32'(s), 32'd0);
    for (int f = 0; f < 4; f++)
      check_byte_frame(s + 160 * f, b5[f], $sformatf("t5 frame%0d", f));
    repeat (60) @(negedge clk);

    $display("[TB] reset during data bit 4");
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    push_byte(8'h0F);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    clear_trace();
    tick_en = 1'b1;
    wait_trace(88, 400, "t6 bit4");
    check_output("t6 tx in bit4", 32'(tx), 32'd0);
    check_output("t6 queued before reset", 32'(fifo_count), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check_output("t6 tx on reset", 32'(tx), 32'd1);
    check_output("t6 fifo_count on reset", 32'(fifo_count), 32'd0);
    check_output("t6 busy on reset", 32'(busy), 32'd0);
    check_output("t6 s_ready on reset", 32'(s_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_trace();
    push_byte(8'h5A);
    wait_done(1, 800, "t6 after reset");
    s = find_start(0);
    check_byte_frame(s, 8'h5A, "t6 clean frame");
    check_output("t6 done tick", 32'((done_q.size() > 0) ? done_q[0] : -1), 32'(s + 160));
    repeat (60) @(negedge clk);
    check_output("t6 single frame", 32'(done_cnt), 32'd1);
    check_output("t6 busy after", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
